rpm_error_gen: RTL
==================

# rpm_error_gen

Front-end of the wheel-speed loop. Decodes one quadrature encoder, counts signed steps over a fixed sample window, and converts the count to a measured speed. It then produces the 17-bit sign-magnitude Q8.8 error (setpoint − measured) that the PI controller consumes. A one-cycle `sample_tick` marks each new error value and serves as the controller's update strobe.

## Interface
- `WINDOW_CYCLES`, 4100: sample window length in `clk` cycles (82 µs at 50 MHz); minimum 4.
- `N_WIDTH`, 17: error/speed word width, fixed at {sign, 16-bit magnitude}.
- `Q_WIDTH`, 8: fractional bits of the magnitude.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `ENC_A`, `ENC_B` in 1 each: raw encoder channels, asynchronous to `clk`.
- `enable` in 1: run measurement.
- `Setpoint_k` in 17: target speed, sign-magnitude Q8.8, units of steps/window.
- `Speed_k` out 17: measured speed, same format.
- `Error_k` out 17: `Setpoint_k` − `Speed_k`, same format.
- `sample_tick` out 1: one-cycle pulse when `Error_k` updates.
- `enc_fault` out 1: sticky flag for an illegal encoder transition.

## Operation
- **Synchronisation:** `ENC_A` and `ENC_B` each pass through a 2-FF synchroniser. A `prev` register holds the last synchronised {A,B}.
- **x4 decode:** 00→01→11→10→00 counts +1; the reverse sequence counts −1. No change counts 0.
- **Illegal transition:** a change in both bits counts 0 and sets `enc_fault`. `enc_fault` clears only on `reset`.
- **Accumulator:** 9-bit two's complement, saturating at +255 and −255. Once saturated, further steps in the same direction are ignored.
- **Window counter:** runs 0..`WINDOW_CYCLES`−1. At terminal count:
  - The accumulator value, including that cycle's step, is latched into the count register.
  - The accumulator reloads with 0.
- **Speed conversion:** `Speed_k` = {count<0, |count|, 8'h00}. A count of 0 always gives sign 0.
- **Error computation:**
  - `Setpoint_k` is sampled in the error cycle.
  - Both operands convert to 18-bit two's complement; a setpoint of −0 is treated as +0.
  - e = S − M. The result converts back to sign-magnitude, with the magnitude saturating at 16'hFFFF.
  - An error of 0 is emitted as +0. −0 never appears on any output.
- **`enable` low:**
  - The window counter and accumulator are held at 0, and `Error_k` is forced to 0.
  - `Speed_k` holds its last value and `sample_tick` stays low.
  - The synchronisers and `prev` keep tracking, so re-enabling causes no spurious step.
- **`reset`:** all registers clear, including the synchronisers and `prev` (to 00). `Speed_k`, `Error_k`, `sample_tick` and `enc_fault` all reset to 0.

## Timing
- **Input to decode:** 2 cycles from pin edge to synchronised value, plus 1 cycle into the accumulator.
- **Window boundary:** with the terminal count at cycle T, `Speed_k` is valid at T+1. `Error_k` and `sample_tick` are valid at T+2.
- **Tick rate:** exactly one `sample_tick` per `WINDOW_CYCLES` while enabled.
- **First tick:** occurs `WINDOW_CYCLES`+1 cycles after `enable` rises, or after `reset` falls with `enable` high.
- **`Error_k` stability:** `Error_k` is stable between ticks. `Setpoint_k` changes affect only the next tick.
- **Reset mid-window:** the partial count is discarded and the window restarts from 0.
- **`enable` falling between T and T+2:** the pending tick is suppressed and `Error_k` goes to 0.

## Structure
- Shared package `pi_loop_pkg`:
  - `N_WIDTH`/`Q_WIDTH` constants.
  - sign-magnitude ↔ two's complement conversion functions, with −0 normalisation and magnitude saturation.
  - The PI controller reuses this package.
- Sub-module `quad_decoder`: synchronisers, `prev` register, step output (−1/0/+1) and fault pulse. The top level holds the window counter, accumulator, speed conversion and error pipeline.

## Test plan
- **Reset:** hold `reset` 3 cycles with encoder toggling → all outputs 0, no `sample_tick` until `WINDOW_CYCLES`+1 cycles after release.
- **Forward:** `WINDOW_CYCLES`=100, 10 forward steps in one window, `Setpoint_k` = +12.0 (17'h00C00) → `Speed_k` = +17'h00A00, `Error_k` = +17'h00200, single tick at T+2.
- **Reverse:** 5 reverse steps, `Setpoint_k` = +3.0 → `Speed_k` = 17'h10500, `Error_k` = +8.0 (17'h00800).
- **Saturation:** `WINDOW_CYCLES`=400, 300 forward steps, `Setpoint_k` = −255.0 (17'h1FF00) → `Speed_k` = +17'h0FF00, `Error_k` = 17'h1FFFF.
- **Fault:** illegal 00→11 transition → no count change, `enc_fault`=1 and held through later windows, cleared only by `reset`.
- **Enable / zero:** drop `enable` mid-window → `Error_k`=0, no tick, window restarts on re-enable. Equal setpoint and speed → `Error_k` = 17'h00000, never 17'h10000.

Source files
------------

// File: rtl/pi_loop_pkg.sv
// Shared sign-magnitude Q8.8 word definitions for the wheel-speed loop.
// Conversion helpers normalise -0 and saturate the magnitude.
package pi_loop_pkg;

  localparam int N_WIDTH = 17;
  localparam int Q_WIDTH = 8;
  localparam int M_WIDTH = N_WIDTH - 1;
  localparam int T_WIDTH = N_WIDTH + 1;

  typedef logic [N_WIDTH-1:0] sm_t;
  typedef logic signed [T_WIDTH-1:0] tc_t;

  // -0 has a zero magnitude, so it lands on +0 here
  function automatic tc_t sm_to_tc(input sm_t v);
    tc_t mag;
    mag = tc_t'({2'b00, v[M_WIDTH-1:0]});
    return v[N_WIDTH-1] ? -mag : mag;
  endfunction

  // sign is dropped whenever the magnitude is zero
  function automatic sm_t tc_to_sm(input tc_t v);
    logic [T_WIDTH-1:0] a;
    logic [M_WIDTH-1:0] m;
    a = v[T_WIDTH-1] ? $unsigned(-v) : $unsigned(v);
    m = (|a[T_WIDTH-1:M_WIDTH]) ? '1 : a[M_WIDTH-1:0];
    return {v[T_WIDTH-1] & (|m), m};
  endfunction

endpackage

// File: rtl/rpm_error_gen_if.sv
// Controller-facing bundle of the speed error generator.
// master = PI controller side, slave = error generator.
interface rpm_error_gen_if;
  import pi_loop_pkg::*;

  logic enable;
  sm_t  Setpoint_k;
  sm_t  Speed_k;
  sm_t  Error_k;
  logic sample_tick;
  logic enc_fault;

  modport master (
    output enable,
    output Setpoint_k,
    input  Speed_k,
    input  Error_k,
    input  sample_tick,
    input  enc_fault
  );

  modport slave (
    input  enable,
    input  Setpoint_k,
    output Speed_k,
    output Error_k,
    output sample_tick,
    output enc_fault
  );

endinterface

// File: rtl/rpm_error_gen_quad_decoder.sv
// Quadrature x4 decoder: synchronisers, previous state, step and fault.
// Gray order 00->01->11->10->00 is forward, {A,B} with A as MSB.
module quad_decoder
  import pi_loop_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enc_a,
  input  logic              enc_b,
  output logic signed [1:0] step,
  output logic              fault
);

  logic [1:0] s1;
  logic [1:0] s2;
  logic [1:0] prv;
  logic [1:0] fwd_of;
  logic [1:0] rev_of;
  logic       up;
  logic       dn;
  logic       bad;

  // two-stage synchroniser plus last-seen state, tracked regardless of enable
  always_ff @(posedge clk) begin
    if (reset) begin
      s1  <= '0;
      s2  <= '0;
      prv <= '0;
    end else begin
      s1  <= {enc_a, enc_b};
      s2  <= s1;
      prv <= s2;
    end
  end

  assign fwd_of = {prv[0], ~prv[1]};
  assign rev_of = {~prv[0], prv[1]};
  assign up     = (s2 == fwd_of);
  assign dn     = (s2 == rev_of);
  assign bad    = ((s2 ^ prv) == 2'b11);

  // classify the transition seen this cycle
  always_comb begin
    step  = 2'sd0;
    fault = 1'b0;
    unique case (1'b1)
      up:      step  = 2'sd1;
      dn:      step  = -2'sd1;
      bad:     fault = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/rpm_error_gen.sv
// Wheel-speed front end: windowed step count, speed word, and error
// (setpoint - speed) in sign-magnitude Q8.8 for the PI controller.
module rpm_error_gen
  import pi_loop_pkg::*;
#(
  parameter int WINDOW_CYCLES = 4100
) (
  input logic           clk,
  input logic           reset,
  input logic           ENC_A,
  input logic           ENC_B,
  rpm_error_gen_if.slave bus
);

  localparam int CW = $clog2(WINDOW_CYCLES);

  logic signed [1:0] step;
  logic              dec_fault;
  logic [CW-1:0]     win;
  logic              term;
  logic signed [8:0] acc;
  logic signed [9:0] sum;
  logic signed [8:0] acc_nxt;
  logic              pend;
  sm_t               spd;
  sm_t               err;
  logic              tick;
  logic              fault;

  function automatic sm_t count_to_sm(input logic signed [8:0] c);
    logic [8:0] a;
    a = c[8] ? $unsigned(-c) : $unsigned(c);
    return {c[8], a[7:0], 8'h00};
  endfunction

  quad_decoder u_dec (
    .clk   (clk),
    .reset (reset),
    .enc_a (ENC_A),
    .enc_b (ENC_B),
    .step  (step),
    .fault (dec_fault)
  );

  assign term = (win == CW'(WINDOW_CYCLES - 1));
  assign sum  = {acc[8], acc} + {{8{step[1]}}, step};

  // saturate the running count at +/-255
  always_comb begin
    acc_nxt = sum[8:0];
    if (sum > 10'sd255) begin
      acc_nxt = 9'sd255;
    end else if (sum < -10'sd255) begin
      acc_nxt = -9'sd255;
    end
  end

  // window counter and step accumulator, parked at 0 while disabled
  always_ff @(posedge clk) begin
    if (reset || !bus.enable) begin
      win <= '0;
      acc <= '0;
    end else if (term) begin
      win <= '0;
      acc <= '0;
    end else begin
      win <= win + 1'b1;
      acc <= acc_nxt;
    end
  end

  // latch the window count as a speed word; flag the error cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      spd  <= '0;
      pend <= 1'b0;
    end else begin
      pend <= bus.enable & term;
      if (bus.enable && term) begin
        spd <= count_to_sm(acc_nxt);
      end
    end
  end

  // error and update strobe, one cycle behind the speed word
  always_ff @(posedge clk) begin
    if (reset || !bus.enable) begin
      err  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= pend;
      if (pend) begin
        err <= tc_to_sm(sm_to_tc(bus.Setpoint_k) - sm_to_tc(spd));
      end
    end
  end

  // sticky encoder fault
  always_ff @(posedge clk) begin
    if (reset) begin
      fault <= 1'b0;
    end else if (dec_fault) begin
      fault <= 1'b1;
    end
  end

  assign bus.Speed_k     = spd;
  assign bus.Error_k     = err;
  assign bus.sample_tick = tick;
  assign bus.enc_fault   = fault;

endmodule
